// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encoding and default widths for the RSA datapath blocks
package rsa_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_CALCULATE,
      STATE_WAITDONE
   } State_t;

   localparam int DEFAULT_MOD_WIDTH   = 256;
   localparam int DEFAULT_POWER_WIDTH = 32;

endpackage

// File: rtl/half_mod_step.sv
// rtl/half_mod_step.sv - one modular halving step: r/2 mod N for odd N
module half_mod_step #(
   parameter int MOD_WIDTH = 256
) (
   input  logic [MOD_WIDTH-1:0] r,
   input  logic [MOD_WIDTH-1:0] n,
   output logic [MOD_WIDTH-1:0] half
);

   logic [MOD_WIDTH:0] sum;

   // Odd r gets N added first so the sum is even; the extra bit keeps the carry.
   always_comb begin
      sum  = {1'b0, r} + (r[0] ? {1'b0, n} : '0);
      half = MOD_WIDTH'(sum >> 1);
   end

endmodule

// File: rtl/half_power_mod.sv
// rtl/half_power_mod.sv - computes value * 2^-power mod modulus, one halving per cycle
module half_power_mod
   import rsa_pkg::*;
#(
   parameter int MOD_WIDTH   = DEFAULT_MOD_WIDTH,
   parameter int POWER_WIDTH = DEFAULT_POWER_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [MOD_WIDTH-1:0]   i_modulus,
   input  logic [MOD_WIDTH-1:0]   i_value,
   input  logic [POWER_WIDTH-1:0] i_power,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [MOD_WIDTH-1:0]   o_out
);

   State_t                 state;
   logic [MOD_WIDTH-1:0]   r;
   logic [MOD_WIDTH-1:0]   n_reg;
   logic [POWER_WIDTH-1:0] k_reg;
   logic [POWER_WIDTH-1:0] cnt;
   logic [MOD_WIDTH-1:0]   r_half;

   half_mod_step #(.MOD_WIDTH(MOD_WIDTH)) u_step (
      .r    (r),
      .n    (n_reg),
      .half (r_half)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= STATE_IDLE;
         i_ready <= 1'b1;
         o_valid <= 1'b0;
         o_out   <= '0;
         cnt     <= '0;
         n_reg   <= '0;
         k_reg   <= '0;
         r       <= '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (i_valid && i_ready) begin
                  n_reg   <= i_modulus;
                  k_reg   <= i_power;
                  r       <= i_value;
                  cnt     <= '0;
                  i_ready <= 1'b0;
                  if (i_power == '0) begin
                     o_out   <= i_value;
                     o_valid <= 1'b1;
                     state   <= STATE_WAITDONE;
                  end else begin
                     state   <= STATE_CALCULATE;
                  end
               end
            end
            STATE_CALCULATE: begin
               r   <= r_half;
               cnt <= cnt + POWER_WIDTH'(1);
               // Equality at full width so k = all-ones runs the full count.
               if (cnt == k_reg - POWER_WIDTH'(1)) begin
                  o_out   <= r_half;
                  o_valid <= 1'b1;
                  state   <= STATE_WAITDONE;
               end
            end
            STATE_WAITDONE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
                  state   <= STATE_IDLE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               i_ready <= 1'b1;
               state   <= STATE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_half_power_mod.sv
// tb/tb_half_power_mod.sv - directed and random checks for half_power_mod
module tb_half_power_mod;

   localparam int MW = 256;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          i_ready;
   logic [MW-1:0] i_modulus;
   logic [MW-1:0] i_value;
   logic [PW-1:0] i_power;
   logic          o_valid;
   logic          o_ready;
   logic [MW-1:0] o_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   half_power_mod #(.MOD_WIDTH(MW), .POWER_WIDTH(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_modulus (i_modulus),
      .i_value   (i_value),
      .i_power   (i_power),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_out     (o_out)
   );

   typedef struct {
      logic [MW-1:0] n;
      logic [MW-1:0] x;
      logic [PW-1:0] k;
      logic [MW-1:0] exp;
      bit            chk_val;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [MW-1:0] rand_word();
      logic [MW-1:0] v;
      for (int i = 0; i < MW / 32; i++) v = {v[MW-33:0], 32'($urandom)};
      return v;
   endfunction

   // Doubling k times must take the result back to x (inverse direction).
   function automatic logic [MW-1:0] double_back(input logic [MW-1:0] r, input logic [MW-1:0] n, input int k);
      logic [MW:0] t;
      t = {1'b0, r};
      for (int i = 0; i < k; i++) begin
         t = {t[MW-1:0], 1'b0};
         if (t >= {1'b0, n}) t = t - {1'b0, n};
      end
      return t[MW-1:0];
   endfunction

   // Inputs are driven 1 time unit after a rising edge; outputs sampled there too.
   task automatic start_op(input logic [MW-1:0] n, input logic [MW-1:0] x, input logic [PW-1:0] k);
      chk("idle_i_ready_before_accept", {255'd0, i_ready}, 256'd1);
      i_modulus = n;
      i_value   = x;
      i_power   = k;
      i_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_valid   = 1'b0;
   endtask

   task automatic do_op(input logic [MW-1:0] n, input logic [MW-1:0] x, input logic [PW-1:0] k,
                        output logic [MW-1:0] res, output int lat, output bit rdy_bad);
      rdy_bad = 1'b0;
      start_op(n, x, k);
      lat = 1;
      while (!o_valid && lat < 2000) begin
         if (i_ready) rdy_bad = 1'b1;
         i_valid   = 1'($urandom);
         i_modulus = rand_word();
         i_value   = rand_word();
         i_power   = 32'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      i_valid = 1'b0;
      if (!o_valid) lat = -1;
      res = o_out;
   endtask

   task automatic finish_op(input string name);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      chk({name, "_ovalid_drop"}, {255'd0, o_valid}, 256'd0);
      chk({name, "_iready_back"}, {255'd0, i_ready}, 256'd1);
   endtask

   initial begin
      logic [MW-1:0] res;
      logic [MW-1:0] nw;
      logic [MW-1:0] xr;
      logic [MW-1:0] nr;
      int            lat;
      int            kr;
      bit            rdy_bad;

      nw = '1;
      nw = nw - 256'd188;
      vecs[0] = '{256'd13, 256'd1,  32'd1,   256'd7, 1'b1};
      vecs[1] = '{256'd13, 256'd1,  32'd4,   256'd9, 1'b1};
      vecs[2] = '{256'd13, 256'd5,  32'd0,   256'd5, 1'b1};
      vecs[3] = '{256'd13, 256'd12, 32'd2,   256'd3, 1'b1};
      vecs[4] = '{256'd7,  256'd3,  32'd3,   256'd3, 1'b1};
      vecs[5] = '{256'd13, 256'd0,  32'd5,   256'd0, 1'b1};
      vecs[6] = '{nw, 256'd189 << 44, 32'd300, 256'd1, 1'b1};
      vecs[7] = '{256'd3,  256'd2,  32'd9,   256'd1, 1'b1};
      vecs[8] = '{256'd12, 256'd20, 32'd3,   256'd0, 1'b0};

      rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
      i_modulus = '0; i_value = '0; i_power = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_i_ready", {255'd0, i_ready}, 256'd1);
      chk("reset_o_valid", {255'd0, o_valid}, 256'd0);
      chk("reset_o_out", o_out, 256'd0);

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].n, vecs[i].x, vecs[i].k, res, lat, rdy_bad);
         chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].k + 1));
         chk($sformatf("vec%0d_iready_low", i), {255'd0, rdy_bad}, 256'd0);
         if (vecs[i].chk_val) chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
         finish_op($sformatf("vec%0d", i));
      end

      // Backpressure: result and flags hold while the consumer stalls.
      do_op(256'd13, 256'd1, 32'd4, res, lat, rdy_bad);
      chk("bp_latency", 256'(lat), 256'd5);
      for (int c = 0; c < 10; c++) begin
         i_valid   = c[0];
         i_modulus = 256'd11;
         i_value   = 256'd3;
         i_power   = 32'd2;
         @(posedge clk);
         #1;
         chk($sformatf("bp_out_c%0d", c), o_out, 256'd9);
         chk($sformatf("bp_ovalid_c%0d", c), {255'd0, o_valid}, 256'd1);
         chk($sformatf("bp_iready_c%0d", c), {255'd0, i_ready}, 256'd0);
      end
      i_valid = 1'b0;
      finish_op("bp");

      // Reset in the middle of a k=4 run aborts it.
      start_op(256'd13, 256'd1, 32'd4);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_o_out", o_out, 256'd0);
      chk("midrst_o_valid", {255'd0, o_valid}, 256'd0);
      chk("midrst_i_ready", {255'd0, i_ready}, 256'd1);
      do_op(256'd13, 256'd1, 32'd1, res, lat, rdy_bad);
      chk("midrst_after_out", res, 256'd7);
      chk("midrst_after_latency", 256'(lat), 256'd2);
      finish_op("midrst_after");

      // Random odd moduli, checked by doubling the result back to x.
      for (int t = 0; t < 30; t++) begin
         nr = rand_word();
         nr[0] = 1'b1;
         if (t[0]) nr[MW-1] = 1'b1;
         xr = rand_word() % nr;
         kr = (t == 0) ? 600 : int'($urandom_range(0, 600));
         do_op(nr, xr, PW'(kr), res, lat, rdy_bad);
         chk($sformatf("rand%0d_latency", t), 256'(lat), 256'(kr + 1));
         chk($sformatf("rand%0d_below_n", t), {255'd0, res < nr}, 256'd1);
         chk($sformatf("rand%0d_inverse", t), double_back(res, nr, kr), xr);
         finish_op($sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
